riscv_core_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit. It sits beside the combinational ALU in the EX stage. It accepts operands from the ALU operand muxes through a valid/ready handshake and returns one XLEN-bit result with a single-cycle done pulse. The EX stage holds the pipeline stalled from acceptance until done.

---
 rtl/riscv_core_muldiv_if.sv | 33 +++
 rtl/riscv_core_muldiv.sv | 151 +++++++++++++++
 tb/tb_riscv_core_muldiv.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/riscv_core_muldiv_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide unit.
//   i_md_valid  : request present this cycle
//   i_md_op     : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   i_md_srcA/B : rs1 / rs2 operands
//   i_md_flush  : abort any in-flight operation
//   o_md_ready  : unit idle, request taken on valid && ready
//   o_md_busy   : operation in flight
//   o_md_done   : one-cycle pulse, o_md_result valid
//   o_md_result : result, held until the next done
// master = EX stage side, slave = muldiv unit side.
interface riscv_core_muldiv_if #(
    parameter int XLEN = 32
);
    logic            i_md_valid;
    logic [2:0]      i_md_op;
    logic [XLEN-1:0] i_md_srcA;
    logic [XLEN-1:0] i_md_srcB;
    logic            i_md_flush;
    logic            o_md_ready;
    logic            o_md_busy;
    logic            o_md_done;
    logic [XLEN-1:0] o_md_result;

    modport master (
        output i_md_valid, i_md_op, i_md_srcA, i_md_srcB, i_md_flush,
        input  o_md_ready, o_md_busy, o_md_done, o_md_result
    );

    modport slave (
        input  i_md_valid, i_md_op, i_md_srcA, i_md_srcB, i_md_flush,
        output o_md_ready, o_md_busy, o_md_done, o_md_result
    );
endinterface

// File: rtl/riscv_core_muldiv.sv
// Iterative RV32M multiply/divide unit living beside the EX-stage ALU.
// Multiply: radix-2 shift-add on operand magnitudes, one bit per cycle.
// Divide: restoring division on magnitudes, one quotient bit per cycle.
// Sign correction and result selection happen in a single FIX cycle.
// Divide-by-zero and signed overflow bypass straight to DONE.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   md    : request/response bundle (slave side), see riscv_core_muldiv_if
module riscv_core_muldiv #(
    parameter int XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    riscv_core_muldiv_if.slave md
);
    localparam int W = XLEN;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    state_t       state_q, state_d;
    logic [4:0]   cnt_q;
    logic [2:0]   op_q;
    logic         sa_q, sb_q;
    logic [W-1:0] mag_a_q, mag_b_q;
    logic [2*W-1:0] prod_q;
    logic [W:0]   rem_q;
    logic [W-1:0] quot_q;
    logic [W-1:0] result_q;

    // ---------------- request decode ----------------
    logic [2:0]   in_op;
    logic [W-1:0] in_a, in_b;
    logic         in_sa, in_sb, a_signed, b_signed;
    logic [W-1:0] in_mag_a, in_mag_b;
    logic         div_zero, div_ovf, bypass, accept;
    logic [W-1:0] bypass_res;

    assign in_op    = md.i_md_op;
    assign in_a     = md.i_md_srcA;
    assign in_b     = md.i_md_srcB;
    assign a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                      (in_op == OP_DIV)  || (in_op == OP_REM);
    assign b_signed = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
    assign in_sa    = a_signed && in_a[W-1];
    assign in_sb    = b_signed && in_b[W-1];
    // -INT_MIN wraps to INT_MIN, which is the correct unsigned magnitude.
    assign in_mag_a = in_sa ? -in_a : in_a;
    assign in_mag_b = in_sb ? -in_b : in_b;

    assign div_zero = in_op[2] && (in_b == '0);
    assign div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                      (in_a == INT_MIN) && (in_b == '1);
    assign bypass   = div_zero || div_ovf;
    // op[1] distinguishes REM/REMU from DIV/DIVU.
    assign bypass_res = div_zero ? (in_op[1] ? in_a : '1)
                                 : (in_op[1] ? '0 : INT_MIN);

    assign accept = md.i_md_valid && (state_q == IDLE) && !md.i_md_flush;

    // ---------------- per-cycle datapath ----------------
    logic [W:0]   mul_sum;
    logic [W:0]   rem_sh;
    logic         rem_ge;

    assign mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
    assign rem_sh  = {rem_q[W-1:0], quot_q[W-1]};
    assign rem_ge  = rem_sh >= {1'b0, mag_b_q};

    // ---------------- sign fix-up ----------------
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;
        quot_fix = ((op_q == OP_DIV) && (sa_q ^ sb_q)) ? -quot_q : quot_q;
        rem_fix  = ((op_q == OP_REM) && sa_q) ? -rem_q[W-1:0] : rem_q[W-1:0];
        fix_res  = '0;
        if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quot_fix;
        else
            fix_res = (op_q == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = bypass ? DONE : CALC;
            CALC: if (cnt_q == 5'd0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (md.i_md_flush) state_d = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt_q   <= 5'd31;
            op_q    <= in_op;
            sa_q    <= in_sa;
            sb_q    <= in_sb;
            mag_a_q <= in_mag_a;
            mag_b_q <= in_mag_b;
            prod_q  <= {{W{1'b0}}, in_mag_b};  // multiplier in low half, shifted out LSB first
            rem_q   <= '0;
            quot_q  <= in_mag_a;               // dividend bits shift into the remainder MSB first
            if (bypass) result_q <= bypass_res;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q - 5'd1;
            if (!op_q[2]) begin
                prod_q <= {mul_sum, prod_q[W-1:1]};
            end else begin
                rem_q  <= rem_ge ? (rem_sh - {1'b0, mag_b_q}) : rem_sh;
                quot_q <= {quot_q[W-2:0], rem_ge};
            end
        end else if ((state_q == FIX) && !md.i_md_flush) begin
            result_q <= fix_res;
        end
    end

    assign md.o_md_ready  = (state_q == IDLE);
    assign md.o_md_busy   = (state_q != IDLE);
    assign md.o_md_done   = (state_q == DONE);
    assign md.o_md_result = result_q;
endmodule

// File: tb/tb_riscv_core_muldiv.sv
// Directed bench for riscv_core_muldiv: inputs driven and outputs sampled on
// the falling edge; the DUT updates on the rising edge.
module tb_riscv_core_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    riscv_core_muldiv_if #(.XLEN(32)) bus ();

    riscv_core_muldiv #(.XLEN(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .md    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for done (bounded), check latency, result,
    // ready low throughout, and that done lasts exactly one cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic ready_seen;
        chk({tag, "_ready_before"}, 32'(bus.o_md_ready), 32'd1);
        bus.i_md_valid = 1'b1;
        bus.i_md_op    = op;
        bus.i_md_srcA  = a;
        bus.i_md_srcB  = b;
        @(negedge clk);
        bus.i_md_valid = 1'b0;
        lat = 1;
        ready_seen = 1'b0;
        while (!bus.o_md_done && lat < 100) begin
            if (bus.o_md_ready) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, bus.o_md_result, exp);
        chk({tag, "_ready_low"}, 32'(ready_seen), 32'd0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(bus.o_md_done), 32'd0);
        chk({tag, "_ready_after"}, 32'(bus.o_md_ready), 32'd1);
    endtask

    initial begin
        int dones;
        bus.i_md_valid = 1'b0;
        bus.i_md_op    = 3'd0;
        bus.i_md_srcA  = '0;
        bus.i_md_srcB  = '0;
        bus.i_md_flush = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready",  32'(bus.o_md_ready), 32'd1);
        chk("rst_busy",   32'(bus.o_md_busy),  32'd0);
        chk("rst_done",   32'(bus.o_md_done),  32'd0);
        chk("rst_result", bus.o_md_result,     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // multiply
        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);

        // divide
        run_op("div",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run_op("rem",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run_op("divu", 3'b101, 32'd100,      32'd7, 32'd14,       34);
        run_op("remu", 3'b111, 32'd100,      32'd7, 32'd2,        34);

        // bypass cases
        run_op("divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_z",   3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // flush 10 cycles into a MUL; previous result is 0 from rem_ovf
        bus.i_md_valid = 1'b1;
        bus.i_md_op    = 3'b000;
        bus.i_md_srcA  = 32'd3;
        bus.i_md_srcB  = 32'd5;
        @(negedge clk);
        bus.i_md_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.o_md_done) dones++;
            @(negedge clk);
        end
        chk("flush_busy_before", 32'(bus.o_md_busy), 32'd1);
        bus.i_md_flush = 1'b1;
        @(negedge clk);
        bus.i_md_flush = 1'b0;
        chk("flush_ready", 32'(bus.o_md_ready), 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (bus.o_md_done) dones++;
            @(negedge clk);
        end
        chk("flush_no_done", 32'(dones), 32'd0);
        chk("flush_result_kept", bus.o_md_result, 32'd0);
        run_op("divu_after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 34);

        // flush coincident with valid in IDLE drops the request
        bus.i_md_valid = 1'b1;
        bus.i_md_flush = 1'b1;
        bus.i_md_op    = 3'b101;
        bus.i_md_srcA  = 32'd8;
        bus.i_md_srcB  = 32'd0;
        @(negedge clk);
        bus.i_md_valid = 1'b0;
        bus.i_md_flush = 1'b0;
        chk("flush_valid_busy", 32'(bus.o_md_busy), 32'd0);
        chk("flush_valid_done", 32'(bus.o_md_done), 32'd0);

        // reset mid-DIV
        bus.i_md_valid = 1'b1;
        bus.i_md_op    = 3'b100;
        bus.i_md_srcA  = 32'd50;
        bus.i_md_srcB  = 32'd5;
        @(negedge clk);
        bus.i_md_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready",  32'(bus.o_md_ready), 32'd1);
        chk("midrst_busy",   32'(bus.o_md_busy),  32'd0);
        chk("midrst_done",   32'(bus.o_md_done),  32'd0);
        chk("midrst_result", bus.o_md_result,     32'd0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_md_done) dones++;
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(dones), 32'd0);

        // valid pulsed while busy is ignored
        bus.i_md_valid = 1'b1;
        bus.i_md_op    = 3'b101;
        bus.i_md_srcA  = 32'd100;
        bus.i_md_srcB  = 32'd7;
        @(negedge clk);
        bus.i_md_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            if (i >= 3 && i < 8) begin
                bus.i_md_valid = 1'b1;
                bus.i_md_op    = 3'b000;
                bus.i_md_srcA  = 32'd2;
                bus.i_md_srcB  = 32'd2;
            end else begin
                bus.i_md_valid = 1'b0;
            end
            if (bus.o_md_done) begin
                dones++;
                chk("busy_valid_result", bus.o_md_result, 32'd14);
            end
            @(negedge clk);
        end
        chk("busy_valid_one_done", 32'(dones), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
